// File: rtl/dpc_arb_pkg.sv
// Shared types for the DPC datapath arbiters.
// The arbiter state encodes whether the output register holds an unconsumed word.
package dpc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage : dpc_arb_pkg

// File: rtl/bn_mux_n_1_generate.sv
// Generic N:1 word selector over a packed bus of 2**SEL_WIDTH slices.
// Slice i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
module bn_mux_n_1_generate #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [(DATA_WIDTH << SEL_WIDTH)-1:0] data,
  input  logic [SEL_WIDTH-1:0]                 sel,
  output logic [DATA_WIDTH-1:0]                y
);

  localparam int N = 1 << SEL_WIDTH;

  logic [DATA_WIDTH-1:0] words [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign words[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign y = words[sel];

endmodule : bn_mux_n_1_generate

// File: rtl/bn_rr_mux_arbiter_rr_priority_pick.sv
// Rotating-priority search: first requester at or after ptr, wrapping modulo N.
// Purely combinational; any_req qualifies winner.
module rr_priority_pick #(
  parameter int SEL_WIDTH = 2
) (
  input  logic [(1 << SEL_WIDTH)-1:0] req,
  input  logic [SEL_WIDTH-1:0]        ptr,
  output logic [SEL_WIDTH-1:0]        winner,
  output logic                        any_req
);

  localparam int N = 1 << SEL_WIDTH;

  logic [SEL_WIDTH-1:0] idx;

  // NOTE: every variable written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    winner = '0;
    idx    = '0;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + SEL_WIDTH'(k);
      if (req[idx]) winner = idx;
    end
  end

  assign any_req = |req;

endmodule : rr_priority_pick

// File: rtl/bn_rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among 2**SEL_WIDTH
// requesters; the winner is acked combinationally and its word captured next edge.
module bn_rr_mux_arbiter
  import dpc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                                 Clk,
  input  logic                                 Rst_n,
  input  logic [(1 << SEL_WIDTH)-1:0]          Req,
  input  logic [(DATA_WIDTH << SEL_WIDTH)-1:0] Data,
  output logic [(1 << SEL_WIDTH)-1:0]          Ack,
  output logic                                 OutValid,
  output logic [DATA_WIDTH-1:0]                OutData,
  input  logic                                 OutReady,
  output logic [SEL_WIDTH-1:0]                 Sel,
  output logic                                 Busy
);

  arb_state_t            state, state_next;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  any_req;
  logic                  load;

  rr_priority_pick #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req     (Req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  bn_mux_n_1_generate #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .data (Data),
    .sel  (winner),
    .y    (win_data)
  );

  assign OutValid = (state == ARB_HOLD);
  // A simultaneous accept and reload keeps the channel at one word per cycle.
  assign load     = any_req && (!OutValid || OutReady);
  assign Busy     = OutValid || any_req;

  // Gate with Rst_n so no requester consumes a word that reset would discard.
  always_comb begin
    Ack = '0;
    if (load && Rst_n) Ack[winner] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (load) state_next = ARB_HOLD;
      ARB_HOLD: if (OutReady && !load) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutData <= '0;
      Sel     <= '0;
      ptr     <= '0;
    end else if (load) begin
      OutData <= win_data;
      Sel     <= winner;
      ptr     <= winner + SEL_WIDTH'(1);
    end
  end

endmodule : bn_rr_mux_arbiter

// File: doc/bn_rr_mux_arbiter.md
Name: bn_rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between 2**SEL_WIDTH requesters.
- It picks a winner among the active requests and steers the winner's data through an N:1 selector. It then captures the data into an output register and holds it under a valid/ready handshake until the consumer accepts it.
- It sits between multiple bus masters (e.g. IO, tape, console sources) and a single shared sink in the DPC datapath.

Parameters:
- DATA_WIDTH, 8, width of each requester's data word and of OutData.
- SEL_WIDTH, 2, select width; number of requesters N = 2**SEL_WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  N  per-requester request; bit i set = Data slice i is valid.
- Data  input  N*DATA_WIDTH  packed requester data; slice i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- Ack  output  N  one-hot combinational grant pulse; the requester consumes its word in the cycle Ack[i]=1.
- OutValid  output  1  output register holds an unconsumed word.
- OutData  output  DATA_WIDTH  registered winning data.
- OutReady  input  1  sink accepts OutData when OutValid&&OutReady.
- Sel  output  SEL_WIDTH  index of the requester whose word is in OutData.
- Busy  output  1  OutValid || (|Req).

Behaviour:
- Reset (Rst_n=0, asynchronous, effective immediately): OutValid=0, OutData=0, Sel=0, Ptr=0, state=ARB_IDLE. Ack is forced to 0 while Rst_n=0.
- Reset asserted mid-transfer discards the held word. There is no Ack replay.
- Ptr (internal, SEL_WIDTH bits) is the highest-priority index.
  - Winner W = the first i in order Ptr, Ptr+1, ..., Ptr+N-1 (mod N) with Req[i]=1.
  - Ptr wrap-around is natural modulo 2**SEL_WIDTH.
- Load = (|Req) && (!OutValid || OutReady).
- In a Load cycle:
  - Ack[W]=1 and all other Ack bits are 0 (combinational, same cycle).
  - At the next edge: OutData<=Data slice W, Sel<=W, OutValid<=1, Ptr<=W+1 mod N.
- Not-Load cycle with OutValid&&OutReady: OutValid<=0. OutData and Sel hold their last values.
- Not-Load cycle with OutValid&&!OutReady: all registers hold. OutData and Sel must be stable while OutValid=1 and OutReady=0.
- Latency: one cycle from Ack to OutValid.
- Throughput: one word per cycle when OutReady stays 1 and requests are present. A simultaneous accept and reload is a back-to-back transfer with no bubble.
- Ack is never asserted while OutValid=1 and OutReady=0 (output full).
- With N requesters continuously requesting, grants rotate strictly 0,1,...,N-1. No requester waits more than N-1 grants.
- A single requester holding Req=1 is granted every cycle the output can load.
- State machine, for documentation and coverage:
  - ARB_IDLE (OutValid=0) -> ARB_HOLD on Load.
  - ARB_HOLD -> ARB_HOLD on Load, or while OutReady=0.
  - ARB_HOLD -> ARB_IDLE on accept without Load.
- Req changing while Ack=0 is legal and has no effect on held data.
- Data slices are sampled only in the Load cycle.

Decomposition:
- Shared package dpc_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_HOLD}.
- Data steering reuses the existing bn_mux_n_1_generate, with sel = W.
- One sub-module, rr_priority_pick (parameter SEL_WIDTH): a combinational block taking Req and Ptr and producing W and AnyReq.

Test Plan (SEL_WIDTH=2, DATA_WIDTH=8, Data slices = 8'hA0, 8'hA1, 8'hA2, 8'hA3):
- Reset check: hold Rst_n=0 mid-transfer with OutValid=1 -> OutValid=0, OutData=0, Sel=0, Ack=0 immediately, asynchronously to Clk.
- All requesting: Req=4'b1111, OutReady=1 for 8 cycles -> Ack one-hot sequence 1,2,4,8,1,2,4,8; OutData sequence A0,A1,A2,A3,A0,... one cycle later; OutValid continuously 1.
- Backpressure: Req=4'b0100, OutReady=0 -> one Ack[2], then OutValid=1, OutData=A2, Sel=2 held and Ack=0 for 5 cycles. OutReady=1 -> accept, and a reload occurs the same cycle if Req[2] is still 1.
- Fairness after wrap: Ptr=3 (after grant to 2), Req=4'b1001 -> grant 3, then grant 0.
- Single requester: Req=4'b0001 with OutReady toggling 1,0,1 -> grant only on cycles where !OutValid||OutReady; no data loss or duplication, verified by scoreboard count.
- Idle drain: Req=0, OutValid=1, OutReady=1 -> OutValid=0 next cycle, Busy=0, Sel unchanged.
